// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two cache-controller request ports, the shared
// main-memory port and the busy flag of mem_arbiter.
//   core n (n = 1, 2): req/we/addr/wdata in, ack/rdata out (arbiter's view)
//   memory           : mem_addr/mem_data/mem_rden/mem_wren out, mem_q in
//   busy             : arbiter is in any state other than idle
// Modport slave is the arbiter's view; master is the view of the
// environment (cores plus memory) driving it.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              req2;
    logic              we2;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata2;
    logic              ack2;
    logic [DATA_W-1:0] rdata2;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic              busy;

    modport slave (
        input  req1, we1, addr1, wdata1,
        input  req2, we2, addr2, wdata2,
        input  mem_q,
        output ack1, rdata1, ack2, rdata2,
        output mem_addr, mem_data, mem_rden, mem_wren,
        output busy
    );

    modport master (
        output req1, we1, addr1, wdata1,
        output req2, we2, addr2, wdata2,
        output mem_q,
        input  ack1, rdata1, ack2, rdata2,
        input  mem_addr, mem_data, mem_rden, mem_wren,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between two cache controllers and a single
// port synchronous main memory. Each granted transaction goes
// IDLE -> ISSUE -> (WAIT for reads) -> DONE and returns one ack pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_arbiter_if.slave: core 1/2 request ports, memory port, busy
// Parameters: ADDR_W/DATA_W bus widths, READ_LAT memory read latency (1..7)
// counted from the strobe cycle to the cycle mem_q is valid.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              last2_q, last2_d;   // 1: core 2 was granted last
    logic              gnt2_q, gnt2_d;     // 1: current grant belongs to core 2
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    // mem_addr/mem_data double as the latched request fields; they are only
    // loaded on a grant, so they also hold their value outside ISSUE/WAIT.
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;
    logic              ack1_q, ack1_d;
    logic              ack2_q, ack2_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              pick2;

    always_comb begin
        state_d    = state_q;
        last2_d    = last2_q;
        gnt2_d     = gnt2_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_rden_d = 1'b0;
        mem_wren_d = 1'b0;
        ack1_d     = 1'b0;
        ack2_d     = 1'b0;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        pick2      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req1 || bus.req2) begin
                    // On a tie the port that was not served last wins.
                    pick2      = bus.req2 && (!bus.req1 || !last2_q);
                    gnt2_d     = pick2;
                    last2_d    = pick2;
                    we_d       = pick2 ? bus.we2 : bus.we1;
                    mem_addr_d = pick2 ? bus.addr2 : bus.addr1;
                    mem_data_d = pick2 ? bus.wdata2 : bus.wdata1;
                    // Strobes are registered, so they are raised on entry
                    // to ISSUE and fall again on its exit.
                    mem_wren_d = we_d;
                    mem_rden_d = !we_d;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    ack1_d  = !gnt2_q;
                    ack2_d  = gnt2_q;
                    state_d = StDone;
                end else begin
                    cnt_d   = 3'(READ_LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (gnt2_q) begin
                        rdata2_d = bus.mem_q;
                    end else begin
                        rdata1_d = bus.mem_q;
                    end
                    ack1_d  = !gnt2_q;
                    ack2_d  = gnt2_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last2_q    <= 1'b1;
            gnt2_q     <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_rden_q <= 1'b0;
            mem_wren_q <= 1'b0;
            ack1_q     <= 1'b0;
            ack2_q     <= 1'b0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
        end else begin
            state_q    <= state_d;
            last2_q    <= last2_d;
            gnt2_q     <= gnt2_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_rden_q <= mem_rden_d;
            mem_wren_q <= mem_wren_d;
            ack1_q     <= ack1_d;
            ack2_q     <= ack2_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
        end
    end

    assign bus.ack1     = ack1_q;
    assign bus.ack2     = ack2_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.rdata2   = rdata2_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_rden = mem_rden_q;
    assign bus.mem_wren = mem_wren_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (READ_LAT 1 and 3) with a delay-line
// memory model. A monitor logs strobes and acks into a ring buffer; each test
// pushes expected events to a queue and pops/compares them afterwards.
module tb_mem_arbiter;

    typedef struct packed {
        logic [15:0] cyc;
        logic        dut;
        logic [2:0]  kind;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] d1;
        logic [31:0] d2;
    } ev_t;

    localparam logic [2:0] KRd = 3'd0, KWr = 3'd1, KAck1 = 3'd2, KAck2 = 3'd3, KBoth = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_v      [2];
    logic        we1_v      [2];
    logic        we2_v      [2];
    logic [11:0] addr1_v    [2];
    logic [11:0] addr2_v    [2];
    logic [31:0] wdata1_v   [2];
    logic [31:0] wdata2_v   [2];
    logic [31:0] mem_word   [2];
    int          issued1    [2];
    int          issued2    [2];
    int          done1      [2];
    int          done2      [2];

    logic        ack1_v     [2];
    logic        ack2_v     [2];
    logic        rden_v     [2];
    logic        wren_v     [2];
    logic        busy_v     [2];
    logic [11:0] mem_addr_v [2];
    logic [31:0] mem_data_v [2];
    logic [31:0] rdata1_v   [2];
    logic [31:0] rdata2_v   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();
        mem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LAT(Lat)) u_dut (
            .clk (clk),
            .rst (rst_v[g]),
            .bus (bus.slave)
        );
        // mem_q carries the word only in the cycle READ_LAT after the strobe.
        logic [7:0] vld = '0;
        always @(posedge clk) vld <= {vld[6:0], bus.mem_rden};
        assign bus.mem_q  = vld[Lat-1] ? mem_word[g] : 32'hBADBAD00;
        assign bus.req1   = (issued1[g] != done1[g]);
        assign bus.we1    = we1_v[g];
        assign bus.addr1  = addr1_v[g];
        assign bus.wdata1 = wdata1_v[g];
        assign bus.req2   = (issued2[g] != done2[g]);
        assign bus.we2    = we2_v[g];
        assign bus.addr2  = addr2_v[g];
        assign bus.wdata2 = wdata2_v[g];
        assign ack1_v[g]     = bus.ack1;
        assign ack2_v[g]     = bus.ack2;
        assign rden_v[g]     = bus.mem_rden;
        assign wren_v[g]     = bus.mem_wren;
        assign busy_v[g]     = bus.busy;
        assign mem_addr_v[g] = bus.mem_addr;
        assign mem_data_v[g] = bus.mem_data;
        assign rdata1_v[g]   = bus.rdata1;
        assign rdata2_v[g]   = bus.rdata2;
    end

    ev_t obs_buf [64];
    int  obs_wr = 0;
    int  obs_rd = 0;
    ev_t exp_q [$];

    // Monitor and requester model: req drops once its ack has been seen.
    always @(negedge clk) begin : mon
        int  w;
        ev_t ev;
        w = obs_wr;
        for (int g = 0; g < 2; g++) begin
            if (ack1_v[g] === 1'b1) done1[g] <= done1[g] + 1;
            if (ack2_v[g] === 1'b1) done2[g] <= done2[g] + 1;
            if (rden_v[g] === 1'b1 || wren_v[g] === 1'b1) begin
                ev      = '0;
                ev.cyc  = 16'(cyc);
                ev.dut  = 1'(g);
                ev.kind = (rden_v[g] && wren_v[g]) ? KBoth : (wren_v[g] ? KWr : KRd);
                ev.addr = mem_addr_v[g];
                ev.data = wren_v[g] ? mem_data_v[g] : 32'h0;
                obs_buf[w % 64] <= ev;
                w++;
            end
            if (ack1_v[g] === 1'b1 || ack2_v[g] === 1'b1) begin
                ev      = '0;
                ev.cyc  = 16'(cyc);
                ev.dut  = 1'(g);
                ev.kind = (ack1_v[g] && ack2_v[g]) ? KBoth : (ack1_v[g] ? KAck1 : KAck2);
                ev.d1   = rdata1_v[g];
                ev.d2   = rdata2_v[g];
                obs_buf[w % 64] <= ev;
                w++;
            end
        end
        obs_wr <= w;
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_rd1 [2];
    logic [31:0] m_rd2 [2];
    int          m_last [2];
    ev_t         e, o;

    function automatic string ev_str(input ev_t x);
        return $sformatf("cyc=%0d dut=%0d kind=%0d addr=%h data=%h rdata1=%h rdata2=%h",
                         x.cyc, x.dut, x.kind, x.addr, x.data, x.d1, x.d2);
    endfunction

    task automatic push(input int c, input int dut, input logic [2:0] kind,
                        input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] r1, input logic [31:0] r2);
        ev_t x;
        x.cyc = 16'(c); x.dut = 1'(dut); x.kind = kind;
        x.addr = a; x.data = d; x.d1 = r1; x.d2 = r2;
        exp_q.push_back(x);
    endtask

    // Bounded wait for all expected events, then a few extra cycles so that
    // spurious strobes or acks also land in the log.
    task automatic wait_events(input int budget);
        int target = obs_rd + exp_q.size();
        for (int i = 0; i < budget && obs_wr < target; i++) begin
            @(negedge clk); #1;
        end
        repeat (4) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            rst_v[g] = 1'b1;
            we1_v[g] = 1'b1; addr1_v[g] = 12'h111; wdata1_v[g] = 32'h11111111;
            we2_v[g] = 1'b1; addr2_v[g] = 12'h222; wdata2_v[g] = 32'h22222222;
            mem_word[g] = 32'h0;
            issued1[g] = 1; issued2[g] = 1;
        end
        repeat (2) begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                n_vec++;
                if ({ack1_v[g], ack2_v[g], rden_v[g], wren_v[g], busy_v[g], mem_addr_v[g],
                     mem_data_v[g], rdata1_v[g], rdata2_v[g]} !== '0) begin
                    n_err++;
                    $display("FAIL reset_values dut%0d: got ack=%b%b rden=%b wren=%b busy=%b",
                             g, ack1_v[g], ack2_v[g], rden_v[g], wren_v[g], busy_v[g],
                             " addr=%h data=%h rd1=%h rd2=%h, required all zero",
                             mem_addr_v[g], mem_data_v[g], rdata1_v[g], rdata2_v[g]);
                end
            end
        end
        begin
            int c0 = cyc;
            rst_v[0] = 1'b0; rst_v[1] = 1'b0;
            for (int g = 0; g < 2; g++) push(c0 + 1, g, KWr, 12'h111, 32'h11111111, 0, 0);
            for (int g = 0; g < 2; g++) push(c0 + 2, g, KAck1, 0, 0, 0, 0);
            for (int g = 0; g < 2; g++) push(c0 + 4, g, KWr, 12'h222, 32'h22222222, 0, 0);
            for (int g = 0; g < 2; g++) push(c0 + 5, g, KAck2, 0, 0, 0, 0);
        end
        for (int g = 0; g < 2; g++) begin
            m_rd1[g] = 32'h0; m_rd2[g] = 32'h0; m_last[g] = 2;
        end
        wait_events(30);
        while (exp_q.size() != 0 || obs_rd != obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL reset extra: got %s, required none", ev_str(obs_buf[obs_rd % 64]));
                obs_rd++;
            end else if (obs_rd == obs_wr) begin
                n_err++;
                $display("FAIL reset missing: got none, required %s", ev_str(exp_q.pop_front()));
            end else begin
                e = exp_q.pop_front(); o = obs_buf[obs_rd % 64]; obs_rd++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL reset event: got %s, required %s", ev_str(o), ev_str(e));
                end
            end
        end
    endtask

    task automatic test_lone_read();
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        mem_word[0] = 32'hDEADBEEF;
        we1_v[0] = 1'b0; addr1_v[0] = 12'h0A4; wdata1_v[0] = 32'h5A5A5A5A;
        issued1[0]++;
        push(c0 + 1, 0, KRd, 12'h0A4, 0, 0, 0);
        push(c0 + 3, 0, KAck1, 0, 0, 32'hDEADBEEF, m_rd2[0]);
        m_rd1[0] = 32'hDEADBEEF; m_last[0] = 1;
        wait_events(20);
        while (exp_q.size() != 0 || obs_rd != obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL lone_read extra: got %s, required none",
                         ev_str(obs_buf[obs_rd % 64]));
                obs_rd++;
            end else if (obs_rd == obs_wr) begin
                n_err++;
                $display("FAIL lone_read missing: got none, required %s",
                         ev_str(exp_q.pop_front()));
            end else begin
                e = exp_q.pop_front(); o = obs_buf[obs_rd % 64]; obs_rd++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL lone_read event: got %s, required %s", ev_str(o), ev_str(e));
                end
            end
        end
        n_vec++;
        if (rdata1_v[0] !== m_rd1[0]) begin
            n_err++;
            $display("FAIL lone_read hold: rdata1 got %h, required %h", rdata1_v[0], m_rd1[0]);
        end
    endtask

    task automatic test_lone_write();
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        we2_v[0] = 1'b1; addr2_v[0] = 12'h3FF; wdata2_v[0] = 32'h12345678;
        issued2[0]++;
        push(c0 + 1, 0, KWr, 12'h3FF, 32'h12345678, 0, 0);
        push(c0 + 2, 0, KAck2, 0, 0, m_rd1[0], m_rd2[0]);
        m_last[0] = 2;
        wait_events(20);
        while (exp_q.size() != 0 || obs_rd != obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL lone_write extra: got %s, required none",
                         ev_str(obs_buf[obs_rd % 64]));
                obs_rd++;
            end else if (obs_rd == obs_wr) begin
                n_err++;
                $display("FAIL lone_write missing: got none, required %s",
                         ev_str(exp_q.pop_front()));
            end else begin
                e = exp_q.pop_front(); o = obs_buf[obs_rd % 64]; obs_rd++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL lone_write event: got %s, required %s", ev_str(o), ev_str(e));
                end
            end
        end
        n_vec++;
        if (rdata2_v[0] !== m_rd2[0]) begin
            n_err++;
            $display("FAIL lone_write rdata2: got %h, required %h", rdata2_v[0], m_rd2[0]);
        end
    endtask

    task automatic test_fairness();
        int c0, p, k1, k2, n1, n2;
        @(posedge clk); #1;
        c0 = cyc;
        p = (m_last[0] == 2) ? 1 : 2;
        k1 = 0; k2 = 0;
        for (int k = 0; k < 8; k++) begin
            if (p == 1) begin
                push(c0 + 3 * k + 1, 0, KWr, 12'(12'h100 + k1), 32'hA0000000 + k1, 0, 0);
                push(c0 + 3 * k + 2, 0, KAck1, 0, 0, m_rd1[0], m_rd2[0]);
                k1++;
            end else begin
                push(c0 + 3 * k + 1, 0, KWr, 12'(12'h200 + k2), 32'hB0000000 + k2, 0, 0);
                push(c0 + 3 * k + 2, 0, KAck2, 0, 0, m_rd1[0], m_rd2[0]);
                k2++;
            end
            m_last[0] = p;
            p = 3 - p;
        end
        n1 = 0; n2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (issued1[0] == done1[0] && n1 < 4) begin
                we1_v[0] = 1'b1; addr1_v[0] = 12'(12'h100 + n1); wdata1_v[0] = 32'hA0000000 + n1;
                issued1[0]++; n1++;
            end
            if (issued2[0] == done2[0] && n2 < 4) begin
                we2_v[0] = 1'b1; addr2_v[0] = 12'(12'h200 + n2); wdata2_v[0] = 32'hB0000000 + n2;
                issued2[0]++; n2++;
            end
            if (n1 == 4 && n2 == 4 && issued1[0] == done1[0] && issued2[0] == done2[0]) break;
            @(posedge clk); #1;
        end
        wait_events(20);
        while (exp_q.size() != 0 || obs_rd != obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fairness extra: got %s, required none",
                         ev_str(obs_buf[obs_rd % 64]));
                obs_rd++;
            end else if (obs_rd == obs_wr) begin
                n_err++;
                $display("FAIL fairness missing: got none, required %s",
                         ev_str(exp_q.pop_front()));
            end else begin
                e = exp_q.pop_front(); o = obs_buf[obs_rd % 64]; obs_rd++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL fairness event: got %s, required %s", ev_str(o), ev_str(e));
                end
            end
        end
    endtask

    task automatic test_latency();
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        mem_word[1] = 32'hCAFEF00D;
        we2_v[1] = 1'b0; addr2_v[1] = 12'h055; wdata2_v[1] = 32'h0F0F0F0F;
        issued2[1]++;
        push(c0 + 1, 1, KRd, 12'h055, 0, 0, 0);
        push(c0 + 5, 1, KAck2, 0, 0, m_rd1[1], 32'hCAFEF00D);
        m_rd2[1] = 32'hCAFEF00D; m_last[1] = 2;
        wait_events(20);
        while (exp_q.size() != 0 || obs_rd != obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL latency extra: got %s, required none",
                         ev_str(obs_buf[obs_rd % 64]));
                obs_rd++;
            end else if (obs_rd == obs_wr) begin
                n_err++;
                $display("FAIL latency missing: got none, required %s",
                         ev_str(exp_q.pop_front()));
            end else begin
                e = exp_q.pop_front(); o = obs_buf[obs_rd % 64]; obs_rd++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL latency event: got %s, required %s", ev_str(o), ev_str(e));
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int c0, c1;
        @(posedge clk); #1;
        c0 = cyc;
        mem_word[0] = 32'h01020304;
        we1_v[0] = 1'b0; addr1_v[0] = 12'h123; wdata1_v[0] = 32'h0;
        issued1[0]++;
        push(c0 + 1, 0, KRd, 12'h123, 0, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        // Now in WAIT: reset and withdraw the request.
        rst_v[0] = 1'b1;
        issued1[0] = done1[0];
        @(posedge clk); #1;
        n_vec++;
        if ({ack1_v[0], ack2_v[0], rden_v[0], wren_v[0], busy_v[0]} !== 5'b0) begin
            n_err++;
            $display("FAIL mid_reset state: got ack=%b%b rden=%b wren=%b busy=%b, required 0",
                     ack1_v[0], ack2_v[0], rden_v[0], wren_v[0], busy_v[0]);
        end
        m_rd1[0] = 32'h0; m_rd2[0] = 32'h0; m_last[0] = 2;
        rst_v[0] = 1'b0;
        c1 = cyc;
        mem_word[0] = 32'h600DF00D;
        we2_v[0] = 1'b0; addr2_v[0] = 12'h2A0; wdata2_v[0] = 32'h0;
        issued2[0]++;
        push(c1 + 1, 0, KRd, 12'h2A0, 0, 0, 0);
        push(c1 + 3, 0, KAck2, 0, 0, 32'h0, 32'h600DF00D);
        m_rd2[0] = 32'h600DF00D;
        wait_events(20);
        while (exp_q.size() != 0 || obs_rd != obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mid_reset extra: got %s, required none",
                         ev_str(obs_buf[obs_rd % 64]));
                obs_rd++;
            end else if (obs_rd == obs_wr) begin
                n_err++;
                $display("FAIL mid_reset missing: got none, required %s",
                         ev_str(exp_q.pop_front()));
            end else begin
                e = exp_q.pop_front(); o = obs_buf[obs_rd % 64]; obs_rd++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL mid_reset event: got %s, required %s", ev_str(o), ev_str(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lone_read();
        test_lone_write();
        test_fairness();
        test_latency();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
